sleep_wdt_ctrl: RTL and testbench

//  Power-down / watchdog sequencer for the PIC16F core. Decodes SLEEP and CLRWDT

---
 rtl/sleep_wdt_ctrl_pkg.sv | 23 ++
 rtl/sleep_wdt_ctrl_sync_edge_det.sv | 31 +++
 rtl/sleep_wdt_ctrl.sv | 130 +++++++++++++
 tb/tb_sleep_wdt_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sleep_wdt_ctrl_pkg.sv
// Shared types and constants for the sleep / watchdog sequencer.
// Holds state encodings, STATUS bit positions and counter sizing.
package sleep_wdt_ctrl_pkg;

    typedef enum logic [1:0] {
        SWC_RUN     = 2'd0,
        SWC_SLEEP   = 2'd1,
        SWC_WAKE    = 2'd2,
        SWC_WDT_RST = 2'd3
    } swc_state_t;

    localparam int STATUS_TO = 4;
    localparam int STATUS_PD = 3;

    // Width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sleep_wdt_ctrl_sync_edge_det.sv
// Multi-flop synchroniser followed by a registered rising-edge pulse.
// Reset value is a parameter so a level held at reset never looks like an edge.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise   <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/sleep_wdt_ctrl.sv
// PIC16F power-down / watchdog sequencer: SLEEP, CLRWDT, wake and WDT reset.
// Owns STATUS TO/PD; stalls the core while asleep and during the wake delay.
module sleep_wdt_ctrl
    import sleep_wdt_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int RST_HOLD_CYCLES = 4,
    parameter int WAKE_CYCLES     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic instr_strobe,
    input  logic exec_sleep,
    input  logic exec_clrwdt,
    input  logic wake_req,
    input  logic wdt_en,
    input  logic wdt_timeout,
    output logic wdt_clr,
    output logic core_stall,
    output logic core_rst,
    output logic wake_pulse,
    output logic status_to,
    output logic status_pd
);

    localparam int HW = cnt_w(RST_HOLD_CYCLES);
    localparam int WW = cnt_w(WAKE_CYCLES);

    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_TERM = WW'(WAKE_CYCLES);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);
    localparam logic          WAKE_STALL = (WAKE_CYCLES != 0);

    swc_state_t    state;
    logic [HW-1:0] hold_cnt;
    logic [WW-1:0] wake_cnt;
    logic          wdt_rise;
    logic          wdt_ev;
    logic          wake_done;

    sync_edge_det #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_wdt_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (wdt_timeout),
        .rise (wdt_rise)
    );

    assign wdt_ev     = wdt_en & wdt_rise;
    assign wake_done  = (wake_cnt == WAKE_TERM);
    assign wake_pulse = (state == SWC_WAKE) & wake_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SWC_RUN;
            hold_cnt   <= '0;
            wake_cnt   <= '0;
            wdt_clr    <= 1'b0;
            core_stall <= 1'b0;
            core_rst   <= 1'b0;
            status_to  <= 1'b1;
            status_pd  <= 1'b1;
        end else begin
            wdt_clr <= 1'b0;
            unique case (state)
                SWC_RUN: begin
                    // A timeout outranks whatever instruction retires this clk.
                    if (wdt_ev) begin
                        state     <= SWC_WDT_RST;
                        hold_cnt  <= '0;
                        wdt_clr   <= 1'b1;
                        core_rst  <= 1'b1;
                        status_to <= 1'b0;
                        status_pd <= 1'b1;
                    end else if (instr_strobe && exec_sleep) begin
                        wdt_clr   <= 1'b1;
                        status_to <= 1'b1;
                        status_pd <= 1'b0;
                        if (!wake_req) begin
                            state      <= SWC_SLEEP;
                            core_stall <= 1'b1;
                        end
                    end else if (instr_strobe && exec_clrwdt) begin
                        wdt_clr   <= 1'b1;
                        status_to <= 1'b1;
                        status_pd <= 1'b1;
                    end
                end
                SWC_SLEEP: begin
                    core_stall <= 1'b1;
                    if (wdt_ev || wake_req) begin
                        state      <= SWC_WAKE;
                        wake_cnt   <= '0;
                        core_stall <= WAKE_STALL;
                        if (wdt_ev) begin
                            status_to <= 1'b0;
                        end
                    end
                end
                SWC_WAKE: begin
                    if (wake_done) begin
                        state      <= SWC_RUN;
                        core_stall <= 1'b0;
                    end else if (instr_strobe) begin
                        wake_cnt <= wake_cnt + 1'b1;
                        // Drop stall together with the wake pulse cycle.
                        if (wake_cnt == WAKE_LAST) begin
                            core_stall <= 1'b0;
                        end
                    end
                end
                SWC_WDT_RST: begin
                    core_stall <= 1'b0;
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= SWC_RUN;
                        core_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= SWC_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sleep_wdt_ctrl.sv
// Self-checking bench for sleep_wdt_ctrl: vector table plus
// hand-written sleep, wake and watchdog sequences.
module tb_sleep_wdt_ctrl;

    logic clk;
    logic rst;
    logic instr_strobe;
    logic exec_sleep;
    logic exec_clrwdt;
    logic wake_req;
    logic wdt_en;
    logic wdt_timeout;
    logic wdt_clr;
    logic core_stall;
    logic core_rst;
    logic wake_pulse;
    logic status_to;
    logic status_pd;

    sleep_wdt_ctrl #(
        .SYNC_STAGES     (2),
        .RST_HOLD_CYCLES (4),
        .WAKE_CYCLES     (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_strobe (instr_strobe),
        .exec_sleep   (exec_sleep),
        .exec_clrwdt  (exec_clrwdt),
        .wake_req     (wake_req),
        .wdt_en       (wdt_en),
        .wdt_timeout  (wdt_timeout),
        .wdt_clr      (wdt_clr),
        .core_stall   (core_stall),
        .core_rst     (core_rst),
        .wake_pulse   (wake_pulse),
        .status_to    (status_to),
        .status_pd    (status_pd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {wdt_clr, core_stall, core_rst, wake_pulse, status_to, status_pd}
    logic [5:0] obs;
    assign obs = {wdt_clr, core_stall, core_rst, wake_pulse, status_to, status_pd};

    typedef struct {
        logic       stb;
        logic       slp;
        logic       clr;
        logic       wk;
        logic       en;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl [14];
    logic [5:0] sb_q [$];
    string      nm_q [$];

    int checks = 0;
    int errors = 0;
    int wp_cnt = 0;
    int rst_cnt = 0;

    task automatic step();
        @(posedge clk);
        #1;
        wp_cnt  += int'(wake_pulse);
        rst_cnt += int'(core_rst);
    endtask

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic sb_push(input string n, input logic [5:0] e);
        sb_q.push_back(e);
        nm_q.push_back(n);
    endtask

    task automatic sb_check();
        logic [5:0] e;
        string      n;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got %b expected queued value", obs);
        end else begin
            e = sb_q.pop_front();
            n = nm_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", n, obs, e);
            end
        end
    endtask

    task automatic instr1(input logic slp, input logic clr, output logic stl);
        instr_strobe = 1'b1;
        exec_sleep   = slp;
        exec_clrwdt  = clr;
        stl          = core_stall;
        step();
        instr_strobe = 1'b0;
        exec_sleep   = 1'b0;
        exec_clrwdt  = 1'b0;
    endtask

    task automatic icyc(input logic slp, input logic clr, output logic stl);
        instr1(slp, clr, stl);
        repeat (3) step();
    endtask

    initial begin
        logic s;
        int   first;
        int   n;
        int   wp0;
        int   rst0;
        int   seen;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000011};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'b100011};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000011};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b000011};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b000011};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'b100010};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000010};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'b100011};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b110010};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'b010010};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b010010};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b010010};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000110};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000010};

        rst          = 1'b1;
        instr_strobe = 1'b0;
        exec_sleep   = 1'b0;
        exec_clrwdt  = 1'b0;
        wake_req     = 1'b0;
        wdt_en       = 1'b1;
        wdt_timeout  = 1'b0;

        repeat (3) step();
        sb_push("reset_state", 6'b000011);
        sb_check();
        rst = 1'b0;

        foreach (tbl[i]) begin
            instr_strobe = tbl[i].stb;
            exec_sleep   = tbl[i].slp;
            exec_clrwdt  = tbl[i].clr;
            wake_req     = tbl[i].wk;
            wdt_en       = tbl[i].en;
            sb_push($sformatf("vec%0d", i), tbl[i].exp);
            step();
            sb_check();
        end
        instr_strobe = 1'b0;
        exec_sleep   = 1'b0;
        exec_clrwdt  = 1'b0;
        wake_req     = 1'b0;
        repeat (4) step();

        // Run-mode timeout: reset pulse timing, then CLRWDT restores TO.
        rst0  = rst_cnt;
        first = 0;
        wdt_timeout = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (core_rst && first == 0) begin
                first = i;
                sb_push("wdtrun_entry", 6'b101001);
                sb_check();
            end
        end
        chk("wdtrun_latency", first, 4);
        chk("wdtrun_rst_width", rst_cnt - rst0, 4);
        sb_push("wdtrun_after", 6'b000001);
        sb_check();
        wdt_timeout = 1'b0;
        repeat (4) step();
        instr1(1'b0, 1'b1, s);
        sb_push("clrwdt_after_to", 6'b100011);
        sb_check();
        repeat (3) step();

        // Sleep, wake_req at the 10th strobe.
        wake_req = 1'b0;
        icyc(1'b1, 1'b0, s);
        wp0 = wp_cnt;
        n   = 0;
        for (int k = 1; k <= 30; k++) begin
            wake_req = (k == 10);
            instr1(1'b0, 1'b0, s);
            wake_req = 1'b0;
            if (s) n++;
            repeat (3) step();
            if (wp_cnt != wp0) break;
        end
        chk("wake_stall_strobes", n, 11);
        chk("wake_pulses", wp_cnt - wp0, 1);
        sb_push("wake_status", 6'b000010);
        sb_check();

        // Sleep, long timeout: one wake, no core reset.
        repeat (6) step();
        icyc(1'b1, 1'b0, s);
        sb_push("sleep_entry", 6'b010010);
        sb_check();
        wp0  = wp_cnt;
        rst0 = rst_cnt;
        wdt_timeout = 1'b1;
        repeat (10) icyc(1'b0, 1'b0, s);
        wdt_timeout = 1'b0;
        repeat (5) step();
        chk("wdtsleep_wakes", wp_cnt - wp0, 1);
        chk("wdtsleep_core_rst", rst_cnt - rst0, 0);
        sb_push("wdtsleep_status", 6'b000000);
        sb_check();

        // Watchdog disabled in RUN and in SLEEP, then reset mid-sleep.
        icyc(1'b0, 1'b1, s);
        wdt_en = 1'b0;
        rst0 = rst_cnt;
        wdt_timeout = 1'b1;
        repeat (10) step();
        wdt_timeout = 1'b0;
        repeat (10) step();
        chk("wdtoff_run_rst", rst_cnt - rst0, 0);
        sb_push("wdtoff_run", 6'b000011);
        sb_check();
        icyc(1'b1, 1'b0, s);
        wp0 = wp_cnt;
        wdt_timeout = 1'b1;
        repeat (10) step();
        wdt_timeout = 1'b0;
        repeat (10) step();
        chk("wdtoff_sleep_wake", wp_cnt - wp0, 0);
        sb_push("wdtoff_sleep", 6'b010010);
        sb_check();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_push("rst_mid_sleep", 6'b000011);
        sb_check();

        // Reset while the core reset is being held.
        wdt_en = 1'b1;
        repeat (3) step();
        wdt_timeout = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (core_rst) begin
                seen = 1;
                break;
            end
        end
        chk("wdtrst_seen", seen, 1);
        rst = 1'b1;
        step();
        wdt_timeout = 1'b0;
        sb_push("rst_mid_wdtrst", 6'b000011);
        sb_check();
        rst = 1'b0;
        repeat (6) step();
        sb_push("after_rst_quiet", 6'b000011);
        sb_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
